// File: rtl/or21nand_vec_checker.sv
// Exhaustive stimulus/response checker for a compound cell (default: or21nand).
// Steps every input vector, waits a settle time, samples nq and scores it against TRUTH.
module or21nand_vec_checker #(
  parameter int unsigned          NIN    = 3,
  parameter logic [(2**NIN)-1:0]  TRUTH  = 8'h1F,
  parameter int unsigned          SETTLE = 2
) (
  input  logic           ck,
  input  logic           nrst,
  input  logic           start,
  input  logic           abort,
  input  logic           nq_in,
  output logic [NIN-1:0] i_out,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [NIN:0]   err_cnt,
  output logic           fail_valid,
  output logic [NIN-1:0] fail_vec
);

  localparam int unsigned NVEC  = 2**NIN;
  localparam int unsigned ERR_W = NIN + 1;
  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [NIN-1:0]   LAST_VEC = NIN'(NVEC - 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  state_e             state_q,      state_d;
  logic [CNT_W-1:0]   cnt_q,        cnt_d;
  logic [NIN-1:0]     i_out_q,      i_out_d;
  logic               busy_q,       busy_d;
  logic               done_q,       done_d;
  logic               pass_q,       pass_d;
  logic [ERR_W-1:0]   err_cnt_q,    err_cnt_d;
  logic               fail_valid_q, fail_valid_d;
  logic [NIN-1:0]     fail_vec_q,   fail_vec_d;
  logic               mismatch_c;

  assign mismatch_c = (nq_in != TRUTH[i_out_q]);

  // Next-state and registered-output logic; abort of a running sweep overrides all.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    i_out_d      = i_out_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    err_cnt_d    = err_cnt_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start && !abort) begin
          state_d      = ST_SETTLE;
          cnt_d        = CNT_INIT;
          i_out_d      = '0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          err_cnt_d    = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
        end
      end

      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_SAMPLE: begin
        if (mismatch_c) begin
          err_cnt_d = err_cnt_q + ERR_W'(1);
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = i_out_q;
          end
        end
        // Last vector leaves the sweep instead of wrapping i_out.
        if (i_out_q == LAST_VEC) begin
          state_d = ST_DONE;
          i_out_d = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == '0);
        end else begin
          state_d = ST_SETTLE;
          i_out_d = i_out_q + NIN'(1);
          cnt_d   = CNT_INIT;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (abort && busy_q) begin
      state_d      = ST_IDLE;
      cnt_d        = '0;
      i_out_d      = '0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      pass_d       = 1'b0;
      err_cnt_d    = '0;
      fail_valid_d = 1'b0;
      fail_vec_d   = '0;
    end
  end

  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      i_out_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_cnt_q    <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      i_out_q      <= i_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_cnt_q    <= err_cnt_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
    end
  end

  assign i_out      = i_out_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_cnt_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;

endmodule
